wrr_flow_classifier: RTL and testbench

- Sits directly upstream of wrr_rank in the rank pipe.
- Takes packet descriptors (lookup key plus metadata) and matches the key against a programmable flow table of MAX_NUM_FLOWS entries.
- On a hit, emits insert, flowID, flow_weight and meta to wrr_rank, honouring its busy back-pressure. Misses are dropped and counted.

---
 rtl/wrr_flow_classifier_pkg.sv | 28 ++
 rtl/wrr_flow_classifier_if.sv | 30 +++
 rtl/wrr_flow_table.sv | 49 ++++
 rtl/wrr_flow_classifier.sv | 107 ++++++++++
 tb/tb_wrr_flow_classifier.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_flow_classifier_pkg.sv
// Shared widths, index-width helper and flow-table entry type for the
// wrr_flow_classifier rank-pipe front end.
package wrr_flow_classifier_pkg;

    localparam int KEY_W         = 32;
    localparam int FLOW_ID_W     = 16;
    localparam int FLOW_WEIGHT_W = 8;
    localparam int META_W        = 16;
    localparam int NUM_FLOWS     = 4;
    localparam int CNT_W         = 32;

    // Index width for n entries; never below one bit so a single-entry table still has a port.
    function automatic int l2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int IDX_W = l2(NUM_FLOWS);

    typedef struct packed {
        logic                     valid;
        logic [KEY_W-1:0]         key;
        logic [FLOW_WEIGHT_W-1:0] weight;
    } flow_entry_t;

endpackage

// File: rtl/wrr_flow_classifier_if.sv
// Descriptor-in / insert-out bundle between the descriptor source, the
// classifier and wrr_rank.
interface wrr_flow_classifier_if
    import wrr_flow_classifier_pkg::*;
#(
    parameter int KEY_WIDTH         = KEY_W,
    parameter int FLOW_ID_WIDTH     = FLOW_ID_W,
    parameter int FLOW_WEIGHT_WIDTH = FLOW_WEIGHT_W,
    parameter int META_WIDTH        = META_W
);
    logic                         desc_valid;
    logic                         desc_ready;
    logic [KEY_WIDTH-1:0]         desc_key;
    logic [META_WIDTH-1:0]        desc_meta;
    logic                         busy;
    logic                         insert;
    logic [FLOW_ID_WIDTH-1:0]     flowID_out;
    logic [FLOW_WEIGHT_WIDTH-1:0] flow_weight_out;
    logic [META_WIDTH-1:0]        meta_out;

    modport master (
        output desc_valid, desc_key, desc_meta, busy,
        input  desc_ready, insert, flowID_out, flow_weight_out, meta_out
    );

    modport slave (
        input  desc_valid, desc_key, desc_meta, busy,
        output desc_ready, insert, flowID_out, flow_weight_out, meta_out
    );
endinterface

// File: rtl/wrr_flow_table.sv
// Register-array flow table with a single write port and a combinational
// parallel key match (lowest matching index wins, weight clamped to >= 1).
module wrr_flow_table
    import wrr_flow_classifier_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_FLOWS,
    parameter int IW          = l2(NUM_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_idx,
    input  logic                     wr_valid,
    input  logic [KEY_W-1:0]         wr_key,
    input  logic [FLOW_WEIGHT_W-1:0] wr_weight,
    input  logic [KEY_W-1:0]         lookup_key,
    output logic                     hit,
    output logic [IW-1:0]            hit_idx,
    output logic [FLOW_WEIGHT_W-1:0] hit_weight
);
    flow_entry_t entries [NUM_ENTRIES];

    // wrr_rank's weight counter starts at 1, so a zero weight would never wrap.
    function automatic logic [FLOW_WEIGHT_W-1:0] clamp_weight(input logic [FLOW_WEIGHT_W-1:0] w);
        return (w == '0) ? FLOW_WEIGHT_W'(1) : w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
        end else if (wr_en && (int'(wr_idx) < NUM_ENTRIES)) begin
            entries[wr_idx] <= '{valid: wr_valid, key: wr_key, weight: wr_weight};
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_weight = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entries[i].valid && (entries[i].key == lookup_key)) begin
                hit        = 1'b1;
                hit_idx    = IW'(i);
                hit_weight = clamp_weight(entries[i].weight);
            end
        end
    end
endmodule

// File: rtl/wrr_flow_classifier.sv
// Two-stage flow classifier feeding wrr_rank: S1 looks the key up, S2 holds
// the hit until wrr_rank is not busy. Misses are dropped out of S1 and counted.
module wrr_flow_classifier
    import wrr_flow_classifier_pkg::*;
#(
    parameter int KEY_WIDTH         = KEY_W,
    parameter int FLOW_ID_WIDTH     = FLOW_ID_W,
    parameter int FLOW_WEIGHT_WIDTH = FLOW_WEIGHT_W,
    parameter int MAX_NUM_FLOWS     = NUM_FLOWS,
    parameter int META_WIDTH        = META_W,
    parameter int CNT_WIDTH         = CNT_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    wrr_flow_classifier_if.slave             bus,
    input  logic                             cfg_wr_en,
    input  logic [l2(MAX_NUM_FLOWS)-1:0]     cfg_idx,
    input  logic                             cfg_entry_valid,
    input  logic [KEY_WIDTH-1:0]             cfg_key,
    input  logic [FLOW_WEIGHT_WIDTH-1:0]     cfg_weight,
    output logic [CNT_WIDTH-1:0]             pkt_cnt,
    output logic [CNT_WIDTH-1:0]             miss_cnt
);
    localparam int IW = l2(MAX_NUM_FLOWS);

    logic                         vld_p1;
    logic [KEY_WIDTH-1:0]         key_p1;
    logic [META_WIDTH-1:0]        meta_p1;
    logic                         hit_p1;
    logic [IW-1:0]                idx_p1;
    logic [FLOW_WEIGHT_WIDTH-1:0] weight_p1;
    logic                         vld_p2;
    logic [IW-1:0]                idx_p2;
    logic [FLOW_WEIGHT_WIDTH-1:0] weight_p2;
    logic [META_WIDTH-1:0]        meta_p2;
    logic                         adv_p1;
    logic                         adv_p2;
    logic                         miss_p1;
    logic                         insert;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    wrr_flow_table #(
        .NUM_ENTRIES (MAX_NUM_FLOWS),
        .IW          (IW)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (cfg_wr_en),
        .wr_idx     (cfg_idx),
        .wr_valid   (cfg_entry_valid),
        .wr_key     (cfg_key),
        .wr_weight  (cfg_weight),
        .lookup_key (key_p1),
        .hit        (hit_p1),
        .hit_idx    (idx_p1),
        .hit_weight (weight_p1)
    );

    // A missing S1 descriptor never needs S2, so it frees S1 regardless of busy.
    assign adv_p2  = ~vld_p2 | ~bus.busy;
    assign miss_p1 = vld_p1 & ~hit_p1;
    assign adv_p1  = ~vld_p1 | miss_p1 | adv_p2;
    assign insert  = vld_p2 & ~bus.busy;

    assign bus.desc_ready      = rst_n & adv_p1;
    assign bus.insert          = insert;
    assign bus.flowID_out      = FLOW_ID_WIDTH'(idx_p2);
    assign bus.flow_weight_out = weight_p2;
    assign bus.meta_out        = meta_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            key_p1    <= '0;
            meta_p1   <= '0;
            vld_p2    <= 1'b0;
            idx_p2    <= '0;
            weight_p2 <= '0;
            meta_p2   <= '0;
            pkt_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            // S1: register the accepted descriptor
            if (adv_p1) begin
                vld_p1 <= bus.desc_valid;
                if (bus.desc_valid) begin
                    key_p1  <= bus.desc_key;
                    meta_p1 <= bus.desc_meta;
                end
            end
            // S2: capture the hit result, frozen against later table writes
            if (adv_p2) begin
                vld_p2 <= vld_p1 & hit_p1;
                if (vld_p1 && hit_p1) begin
                    idx_p2    <= idx_p1;
                    weight_p2 <= weight_p1;
                    meta_p2   <= meta_p1;
                end
            end
            if (insert)  pkt_cnt  <= sat_inc(pkt_cnt);
            if (miss_p1) miss_cnt <= sat_inc(miss_cnt);
        end
    end
endmodule

// File: tb/tb_wrr_flow_classifier.sv
// Randomized scoreboard bench for wrr_flow_classifier against a table-lookup
// reference model; stimulus pushes expectations, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_wrr_flow_classifier;
    import wrr_flow_classifier_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     cfg_wr_en;
    logic [IDX_W-1:0]         cfg_idx;
    logic                     cfg_entry_valid;
    logic [KEY_W-1:0]         cfg_key;
    logic [FLOW_WEIGHT_W-1:0] cfg_weight;
    logic [CNT_W-1:0]         pkt_cnt;
    logic [CNT_W-1:0]         miss_cnt;

    wrr_flow_classifier_if bus ();

    wrr_flow_classifier dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_idx         (cfg_idx),
        .cfg_entry_valid (cfg_entry_valid),
        .cfg_key         (cfg_key),
        .cfg_weight      (cfg_weight),
        .pkt_cnt         (pkt_cnt),
        .miss_cnt        (miss_cnt)
    );

    typedef struct {
        int                id;
        int                w;
        logic [META_W-1:0] meta;
        int                acc_cyc;
    } exp_t;

    bit                m_valid  [NUM_FLOWS];
    logic [KEY_W-1:0]  m_key    [NUM_FLOWS];
    int                m_weight [NUM_FLOWS];
    exp_t              sb [$];
    int                lat_q [$];
    int                exp_pkts = 0;
    int                exp_miss = 0;
    int                cyc = 0;
    int                acc_cnt = 0;
    int                ins_cnt = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    int                stall_base_acc;
    int                stall_base_ins;
    bit                rand_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_lookup(input logic [KEY_W-1:0] k);
        for (int i = 0; i < NUM_FLOWS; i++)
            if (m_valid[i] && m_key[i] == k) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_FLOWS; i++) begin
            m_valid[i]  = 1'b0;
            m_key[i]    = '0;
            m_weight[i] = 0;
        end
        sb.delete();
        exp_pkts = 0;
        exp_miss = 0;
    endtask

    // Monitor: one visit per cycle, between active edges.
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        cyc++;
        if (rst_n) begin
            if (bus.busy) chk("insert_while_busy", 64'(bus.insert), 64'd0);
            if (bus.insert) begin
                ins_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_insert", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("flow_id", 64'(bus.flowID_out), 64'(e.id));
                    chk("flow_weight", 64'(bus.flow_weight_out), 64'(e.w));
                    chk("meta", 64'(bus.meta_out), 64'(e.meta));
                    lat_q.push_back(cyc - e.acc_cyc);
                end
            end
            // A write this cycle is visible to anything accepted this cycle.
            if (cfg_wr_en) begin
                m_valid[cfg_idx]  = cfg_entry_valid;
                m_key[cfg_idx]    = cfg_key;
                m_weight[cfg_idx] = int'(cfg_weight);
            end
            if (bus.desc_valid && bus.desc_ready) begin
                acc_cnt++;
                idx = model_lookup(bus.desc_key);
                if (idx >= 0) begin
                    sb.push_back('{id: idx, w: (m_weight[idx] == 0) ? 1 : m_weight[idx],
                                   meta: bus.desc_meta, acc_cyc: cyc});
                    exp_pkts++;
                end else begin
                    exp_miss++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input bit v, input logic [KEY_W-1:0] k, input int w);
        cfg_wr_en       = 1'b1;
        cfg_idx         = IDX_W'(idx);
        cfg_entry_valid = v;
        cfg_key         = k;
        cfg_weight      = FLOW_WEIGHT_W'(w);
        tick();
        cfg_wr_en       = 1'b0;
    endtask

    task automatic send(input logic [KEY_W-1:0] k, input logic [META_W-1:0] m);
        int guard;
        guard = 0;
        bus.desc_valid = 1'b1;
        bus.desc_key   = k;
        bus.desc_meta  = m;
        @(negedge clk);
        while (!bus.desc_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.desc_ready) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b0;
    endtask

    task automatic checkpoint(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        if (sb.size() != 0) chk({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
        repeat (3) tick();
        chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkts));
        chk({name, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        logic [KEY_W-1:0] pool [6];
        bus.desc_valid  = 1'b0;
        bus.desc_key    = '0;
        bus.desc_meta   = '0;
        bus.busy        = 1'b0;
        cfg_wr_en       = 1'b0;
        cfg_idx         = '0;
        cfg_entry_valid = 1'b0;
        cfg_key         = '0;
        cfg_weight      = '0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_desc_ready", 64'(bus.desc_ready), 64'd0);
        chk("rst_insert", 64'(bus.insert), 64'd0);
        chk("rst_flow_id", 64'(bus.flowID_out), 64'd0);
        chk("rst_weight", 64'(bus.flow_weight_out), 64'd0);
        chk("rst_meta", 64'(bus.meta_out), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back hits, second with zero weight.
        cfg_write(0, 1'b1, 32'h0A00_0001, 2);
        cfg_write(1, 1'b1, 32'h0A00_0002, 0);
        lat_q.delete();
        send(32'h0A00_0001, 16'h1111);
        send(32'h0A00_0002, 16'h2222);
        checkpoint("b2b");
        chk("b2b_pkt_cnt_abs", 64'(pkt_cnt), 64'd2);
        chk("b2b_inserts", 64'(lat_q.size()), 64'd2);
        if (lat_q.size() == 2) begin
            chk("b2b_latency0", 64'(lat_q[0]), 64'd2);
            chk("b2b_latency1", 64'(lat_q[1]), 64'd2);
        end

        // Miss drop.
        send(32'hDEAD_BEEF, 16'h3333);
        @(negedge clk);
        chk("miss_ready_0", 64'(bus.desc_ready), 64'd1);
        @(negedge clk);
        chk("miss_ready_1", 64'(bus.desc_ready), 64'd1);
        tick();
        checkpoint("miss");
        chk("miss_cnt_abs", 64'(miss_cnt), 64'd1);

        // Back-pressure from the first S2 fill.
        stall_base_acc = acc_cnt;
        stall_base_ins = ins_cnt;
        send(32'h0A00_0001, 16'h4000);
        fork
            begin
                @(posedge clk);
                #1;
                bus.busy = 1'b1;
                repeat (6) @(negedge clk);
                chk("stall_ready", 64'(bus.desc_ready), 64'd0);
                chk("stall_accepts", 64'(acc_cnt - stall_base_acc), 64'd2);
                chk("stall_no_insert", 64'(ins_cnt - stall_base_ins), 64'd0);
                @(posedge clk);
                #1;
                bus.busy = 1'b0;
            end
        join_none
        for (int i = 1; i < 5; i++)
            send((i % 2 == 0) ? 32'h0A00_0001 : 32'h0A00_0002, 16'(16'h4000 + i));
        checkpoint("stall");
        chk("stall_insert_total", 64'(ins_cnt - stall_base_ins), 64'd5);

        // Write racing the S1 compare sees the old entry.
        k = 32'hC0A8_0005;
        send(k, 16'h5001);
        cfg_write(2, 1'b1, k, 3);
        send(k, 16'h5002);
        checkpoint("wr_race");

        // Duplicate keys: lowest index wins.
        cfg_write(1, 1'b1, 32'h0000_BEEF, 5);
        cfg_write(3, 1'b1, 32'h0000_BEEF, 7);
        send(32'h0000_BEEF, 16'h6001);
        checkpoint("dup");

        // Reset with both stages holding descriptors.
        bus.busy = 1'b1;
        send(32'h0A00_0001, 16'h7001);
        send(32'h0000_BEEF, 16'h7002);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("midrst_insert", 64'(bus.insert), 64'd0);
        chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("midrst_miss_cnt", 64'(miss_cnt), 64'd0);
        chk("midrst_ready", 64'(bus.desc_ready), 64'd0);
        bus.busy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
        send(32'h0A00_0001, 16'h7003);
        checkpoint("post_rst");
        chk("post_rst_miss_abs", 64'(miss_cnt), 64'd1);

        // Random rounds: fresh table, random keys, random back-pressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) pool[i] = 32'h100 + i + r * 16;
            for (int i = 0; i < NUM_FLOWS; i++)
                cfg_write(i, ($urandom_range(0, 3) != 0), pool[$urandom_range(0, 5)],
                          $urandom_range(0, 3));
            rand_on = 1'b1;
            fork
                begin
                    while (rand_on) begin
                        @(posedge clk);
                        #1;
                        bus.busy = ($urandom_range(0, 3) == 0);
                    end
                    bus.busy = 1'b0;
                end
            join_none
            for (int n = 0; n < 60; n++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send(($urandom_range(0, 4) != 0) ? pool[$urandom_range(0, 5)] : KEY_W'($urandom),
                     META_W'($urandom));
            end
            rand_on = 1'b0;
            repeat (2) tick();
            checkpoint("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end of stimulus");
        $fatal(1, "timeout");
    end
endmodule
